// File: rtl/switch_event_encoder.sv
`default_nettype none
// ============================================================================
// Module   : switch_event_encoder
// Brief    : Synchronises and debounces four slide switches, then encodes a
//            single-switch press into a one-cycle event with a running count.
//            Define SWITCH_EVENT_DEBOUNCE_EN to include the debounce counters.
// Revision : 1.0 - initial release
// ============================================================================
module switch_event_encoder #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] sw,
    output logic       evt_valid,
    output logic [1:0] evt_code,
    output logic       evt_err,
    output logic       held,
    output logic [3:0] sw_db,
    output logic [7:0] evt_count
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_HELD = 1'b1
    } state_t;

    logic [3:0] r_sync1;
    logic [3:0] r_sync2;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= sw;
            r_sync2 <= r_sync1;
        end
    end

    // Values outside 1..65535 do not fit the 16-bit stability counters.
    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 65535) begin : g_bad_debounce_cycles
    end

`ifdef SWITCH_EVENT_DEBOUNCE_EN
    localparam logic [15:0] c_CNT_LAST = 16'(DEBOUNCE_CYCLES - 1);

    for (genvar gi = 0; gi < 4; gi++) begin : g_debounce
        logic [15:0] r_cnt;
        logic        r_db;

        always_ff @(posedge clk) begin
            if (reset) begin
                r_cnt <= '0;
                r_db  <= 1'b0;
            end else if (r_sync2[gi] == r_db) begin
                r_cnt <= '0;
            end else if (r_cnt == c_CNT_LAST) begin
                r_db  <= r_sync2[gi];
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 16'd1;
            end
        end

        assign sw_db[gi] = r_db;
    end
`else
    assign sw_db = r_sync2;
`endif

    logic       w_any;
    logic       w_onehot;
    logic [1:0] w_index;

    assign w_any    = |sw_db;
    assign w_onehot = w_any && ((sw_db & (sw_db - 4'd1)) == 4'd0);

    always_comb begin
        w_index = 2'd0;
        if (sw_db[1]) w_index = 2'd1;
        if (sw_db[2]) w_index = 2'd2;
        if (sw_db[3]) w_index = 2'd3;
    end

    state_t     r_state;
    logic       r_valid;
    logic       r_err;
    logic [1:0] r_code;
    logic [7:0] r_count;

    // Only the IDLE->HELD transition can strobe, so each press yields at most one pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            r_code  <= 2'd0;
            r_count <= 8'd0;
        end else begin
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        if (w_onehot) begin
                            r_valid <= 1'b1;
                            r_code  <= w_index;
                            r_count <= r_count + 8'd1;
                        end else begin
                            r_err <= 1'b1;
                        end
                        r_state <= S_HELD;
                    end
                end
                S_HELD: begin
                    if (!w_any) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign evt_valid = r_valid;
    assign evt_err   = r_err;
    assign evt_code  = r_code;
    assign evt_count = r_count;
    assign held      = (r_state == S_HELD);

endmodule

`default_nettype wire

// File: tb/tb_switch_event_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_switch_event_encoder
// Brief    : Timestamp-based reference model plus directed and random stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_switch_event_encoder;

    localparam int DC = 4;
`ifdef SWITCH_EVENT_DEBOUNCE_EN
    localparam int C_STEPS = DC + 3;
`else
    localparam int C_STEPS = 3;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] sw = 4'd0;
    logic       evt_valid, evt_err, held;
    logic [1:0] evt_code;
    logic [3:0] sw_db;
    logic [7:0] evt_count;

    switch_event_encoder #(.DEBOUNCE_CYCLES(DC)) u_dut (
        .clk       (clk),
        .reset     (reset),
        .sw        (sw),
        .evt_valid (evt_valid),
        .evt_code  (evt_code),
        .evt_err   (evt_err),
        .held      (held),
        .sw_db     (sw_db),
        .evt_count (evt_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a switch bit is accepted once its synchronised value has
    // differed from the debounced value continuously for DC edges since it last changed.
    int          m_edge = 0;
    int          m_tchg [4];
    logic [3:0]  m_s1, m_s2, m_db, m_db_old, m_s2_new;
    bit          m_held, m_init = 0;
    logic        m_v, m_e;
    logic [1:0]  m_code;
    logic [7:0]  m_cnt;

    always @(posedge clk) begin
        m_edge++;
        if (reset) begin
            m_s1 = 0; m_s2 = 0; m_db = 0; m_held = 0;
            m_v = 0; m_e = 0; m_code = 0; m_cnt = 0; m_init = 1;
            for (int i = 0; i < 4; i++) m_tchg[i] = m_edge;
        end else begin
            m_db_old = m_db;
            m_v = 0; m_e = 0;
            if (!m_held) begin
                if (m_db_old != 0) begin
                    if ($countones(m_db_old) == 1) begin
                        m_v = 1;
                        for (int i = 0; i < 4; i++) if (m_db_old[i]) m_code = 2'(i);
                        m_cnt = m_cnt + 8'd1;
                    end else begin
                        m_e = 1;
                    end
                    m_held = 1;
                end
            end else if (m_db_old == 0) begin
                m_held = 0;
            end
`ifdef SWITCH_EVENT_DEBOUNCE_EN
            for (int i = 0; i < 4; i++)
                if (m_s2[i] != m_db[i] && (m_edge - m_tchg[i]) >= DC) m_db[i] = m_s2[i];
`endif
            m_s2_new = m_s1;
            for (int i = 0; i < 4; i++) if (m_s2_new[i] != m_s2[i]) m_tchg[i] = m_edge;
            m_s2 = m_s2_new;
            m_s1 = sw;
`ifndef SWITCH_EVENT_DEBOUNCE_EN
            m_db = m_s2;
`endif
        end
    end

    logic [1:0] ev_log [$];

    always @(negedge clk) begin
        if (m_init) begin
            check("evt_valid", {31'd0, evt_valid}, {31'd0, m_v});
            check("evt_err",   {31'd0, evt_err},   {31'd0, m_e});
            check("evt_code",  {30'd0, evt_code},  {30'd0, m_code});
            check("held",      {31'd0, held},      {31'd0, m_held});
            check("sw_db",     {28'd0, sw_db},     {28'd0, m_db});
            check("evt_count", {24'd0, evt_count}, {24'd0, m_cnt});
            if (evt_valid === 1'b1) ev_log.push_back(evt_code);
            if (evt_valid === 1'b1 && evt_err === 1'b1) check("valid_and_err", 1, 0);
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_strobe(input bit want_err, output int lat);
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if ((want_err ? evt_err : evt_valid) === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic wait_idle();
        bit done = 0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            if (held === 1'b0 && sw_db === 4'd0) done = 1;
        end
        check("idle_timeout", {31'd0, done}, 32'd1);
    endtask

    int lat;
    int base;

    initial begin
        step(3);
        reset = 1'b0;
        step(1);
        check("rst_held",  {31'd0, held}, 0);
        check("rst_count", {24'd0, evt_count}, 0);
        check("rst_sw_db", {28'd0, sw_db}, 0);
        check("rst_code",  {30'd0, evt_code}, 0);

        // Single press of switch 2
        sw = 4'b0100;
        wait_strobe(0, lat);
        check("press_latency", lat, C_STEPS);
        check("press_code",  {30'd0, evt_code}, 2);
        check("press_count", {24'd0, evt_count}, 1);
        check("press_held",  {31'd0, held}, 1);
        sw = 4'b0000;
        wait_idle();

`ifdef SWITCH_EVENT_DEBOUNCE_EN
        // Three-cycle glitch must be rejected
        sw = 4'b0010;
        step(3);
        sw = 4'b0000;
        step(DC + 6);
        check("glitch_count", {24'd0, evt_count}, 1);
        check("glitch_sw_db", {28'd0, sw_db}, 0);
`endif

        // Two switches at once -> error strobe
        base = ev_log.size();
        sw = 4'b1010;
        wait_strobe(1, lat);
        check("err_latency", lat, C_STEPS);
        check("err_code",  {30'd0, evt_code}, 2);
        check("err_count", {24'd0, evt_count}, 1);
        check("err_held",  {31'd0, held}, 1);
        sw = 4'b0000;
        wait_idle();
        check("err_no_valid", ev_log.size() - base, 0);

        // Overlapping press yields no extra event
        ev_log.delete();
        sw = 4'b0001;
        step(C_STEPS + 2);
        sw = 4'b1001;
        step(DC + 6);
        sw = 4'b0000;
        wait_idle();
        sw = 4'b1000;
        step(C_STEPS + 2);
        sw = 4'b0000;
        wait_idle();
        check("overlap_events", ev_log.size(), 2);
        if (ev_log.size() == 2) begin
            check("overlap_code0", {30'd0, ev_log[0]}, 0);
            check("overlap_code1", {30'd0, ev_log[1]}, 3);
        end

        // Count wrap after 256 presses
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        ev_log.delete();
        for (int k = 0; k < 256; k++) begin
            sw = 4'b0100;
            step(C_STEPS + 1);
            sw = 4'b0000;
            wait_idle();
        end
        check("wrap_events", ev_log.size(), 256);
        check("wrap_count", {24'd0, evt_count}, 0);

        // Reset while held, switch still on
        sw = 4'b0100;
        step(C_STEPS + 2);
        check("pre_rst_held", {31'd0, held}, 1);
        reset = 1'b1;
        step(1);
        check("mid_rst_held",  {31'd0, held}, 0);
        check("mid_rst_count", {24'd0, evt_count}, 0);
        check("mid_rst_sw_db", {28'd0, sw_db}, 0);
        check("mid_rst_code",  {30'd0, evt_code}, 0);
        reset = 1'b0;
        wait_strobe(0, lat);
        check("post_rst_latency", lat, C_STEPS);
        check("post_rst_code",  {30'd0, evt_code}, 2);
        check("post_rst_count", {24'd0, evt_count}, 1);
        sw = 4'b0000;
        wait_idle();

        // Random traffic, including hold times around the debounce window
        for (int k = 0; k < 300; k++) begin
            int r = $urandom_range(0, 9);
            if (r < 4)      sw = 4'b0000;
            else if (r < 8) sw = 4'(1 << $urandom_range(0, 3));
            else            sw = 4'($urandom);
            reset = ($urandom_range(0, 39) == 0);
            step(1);
            reset = 1'b0;
            step($urandom_range(0, DC + 4));
        end
        sw = 4'b0000;
        step(20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
